// File: rtl/bu_operand_router.sv
// Operand router between the coefficient bank ports and the butterfly array: permutes each beat
// into (top, bottom) lane pairs by stage length. BU_ROUTER_SKID_EN selects a 2-entry skid output.
module bu_operand_router #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned NUM_BU     = 8,
  parameter int unsigned N_COEFF    = 256,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [LEN_WIDTH-1:0]         len_i,
  input  logic                         mode_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [NUM_BU*DATA_WIDTH-1:0] data_a_i,
  input  logic [NUM_BU*DATA_WIDTH-1:0] data_b_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [NUM_BU*DATA_WIDTH-1:0] bu_a_o,
  output logic [NUM_BU*DATA_WIDTH-1:0] bu_b_o,
  output logic                         mode_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         len_err_o
);

  localparam int unsigned BusW   = NUM_BU * DATA_WIDTH;
  localparam int unsigned Beats  = N_COEFF / (2 * NUM_BU);
  localparam int unsigned CntW   = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned MaxLen = N_COEFF / 2;
  localparam int unsigned IdxW   = $clog2(2 * NUM_BU);
  localparam logic [CntW-1:0]      LastBeat = CntW'(Beats - 1);
  localparam logic [LEN_WIDTH-1:0] LenOne   = LEN_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                 state_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic                   mode_q;
  logic [CntW-1:0]        beat_q;
  logic                   done_q;
  logic                   len_err_q;

  logic                   len_ok;
  logic                   last_beat;
  logic                   push;
  logic                   pop;
  logic                   buf_empty_d;

  // Powers of two only: exactly one bit set, and no larger than half a polynomial.
  assign len_ok    = (len_i != '0) && ((len_i & (len_i - LenOne)) == '0) &&
                     (32'(len_i) <= MaxLen);
  assign last_beat = (beat_q == LastBeat);
  assign push      = in_valid_i & in_ready_o;
  assign pop       = out_valid_o & out_ready_i;

  assign mode_o    = mode_q;
  assign busy_o    = (state_q != StIdle);
  assign done_o    = done_q;
  assign len_err_o = len_err_q;

  // ---------------------------------------------------------------------------------------------
  // Lane permutation
  // ---------------------------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] v [2*NUM_BU];
  logic [BusW-1:0]       perm_a;
  logic [BusW-1:0]       perm_b;
  int unsigned           len_w;
  int unsigned           len_m;
  int unsigned           top;
  int unsigned           bot;
  logic [IdxW-1:0]       top_idx;
  logic [IdxW-1:0]       bot_idx;

  always_comb begin
    for (int unsigned k = 0; k < NUM_BU; k++) begin
      v[k]          = data_a_i[k*DATA_WIDTH +: DATA_WIDTH];
      v[NUM_BU + k] = data_b_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
    perm_a  = data_a_i;
    perm_b  = data_b_i;
    len_w   = 32'(len_q);
    len_m   = len_w - 1;
    top     = 0;
    bot     = 0;
    top_idx = '0;
    bot_idx = '0;
    if (len_w < NUM_BU) begin
      for (int unsigned j = 0; j < NUM_BU; j++) begin
        // len is a power of two: group bits shift up one, offset bits stay put.
        top     = ((j & ~len_m) << 1) | (j & len_m);
        bot     = top + len_w;
        top_idx = IdxW'(top);
        bot_idx = IdxW'(bot);
        perm_a[j*DATA_WIDTH +: DATA_WIDTH] = v[top_idx];
        perm_b[j*DATA_WIDTH +: DATA_WIDTH] = v[bot_idx];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------------------------
`ifdef BU_ROUTER_SKID_EN
  logic [BusW-1:0] a0_q, b0_q, a1_q, b1_q;
  logic [BusW-1:0] a0_d, b0_d, a1_d, b1_d;
  logic [1:0]      occ_q, occ_d;
  logic            in_ready_q;
  logic            next_run;

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (occ_q != 2'd0);
  assign bu_a_o      = a0_q;
  assign bu_b_o      = b0_q;
  assign buf_empty_d = (occ_d == 2'd0);
  assign next_run    = ((state_q == StIdle) && start_i && len_ok) ||
                       ((state_q == StRun) && !(push && last_beat));

  always_comb begin
    a0_d  = a0_q;
    b0_d  = b0_q;
    a1_d  = a1_q;
    b1_d  = b1_q;
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          a0_d = perm_a;
          b0_d = perm_b;
        end else begin
          a1_d = perm_a;
          b1_d = perm_b;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        a0_d  = a1_q;
        b0_d  = b1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          a0_d = perm_a;
          b0_d = perm_b;
        end else begin
          a0_d = a1_q;
          b0_d = b1_q;
          a1_d = perm_a;
          b1_d = perm_b;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a0_q       <= '0;
      b0_q       <= '0;
      a1_q       <= '0;
      b1_q       <= '0;
      occ_q      <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      a0_q       <= a0_d;
      b0_q       <= b0_d;
      a1_q       <= a1_d;
      b1_q       <= b1_d;
      occ_q      <= occ_d;
      // Registered so the bank side never sees a path from out_ready_i.
      in_ready_q <= next_run && (occ_d != 2'd2);
    end
  end
`else
  logic [BusW-1:0] a_q, b_q;
  logic            valid_q, valid_d;

  assign in_ready_o  = (state_q == StRun) & (~valid_q | out_ready_i);
  assign out_valid_o = valid_q;
  assign bu_a_o      = a_q;
  assign bu_b_o      = b_q;
  assign valid_d     = push ? 1'b1 : (pop ? 1'b0 : valid_q);
  assign buf_empty_d = ~valid_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (push) begin
        a_q <= perm_a;
        b_q <= perm_b;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------------------------
  // Stage control
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      len_q     <= '0;
      mode_q    <= 1'b0;
      beat_q    <= '0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (len_ok) begin
              len_q   <= len_i;
              mode_q  <= mode_i;
              beat_q  <= '0;
              state_q <= StRun;
            end else begin
              len_err_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (push) begin
            // Counter holds at the last beat; it is cleared on the next start.
            if (last_beat) state_q <= StDrain;
            else           beat_q  <= beat_q + CntW'(1);
          end
        end
        StDrain: begin
          if (buf_empty_d) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
